// File: rtl/neuron_sequencer_if.sv
// Bus between neuron_sequencer (master) and the MAC datapath / ROMs /
// result buffer (slave). Clock and reset stay plain ports on the sequencer.
interface neuron_sequencer_if #(
   parameter int IN_AW = 4,
   parameter int W_AW  = 7,
   parameter int N_AW  = 3
);
   logic              start;
   logic              abort;
   logic [7:0]        dp_out;
   logic              busy;
   logic              done;
   logic [IN_AW-1:0]  in_addr;
   logic [W_AW-1:0]   weight_addr;
   logic              input_register;
   logic              acc_reset;
   logic              acc_en;
   logic              result_we;
   logic [N_AW-1:0]   result_addr;
   logic [7:0]        result_data;

   modport master (
      input  start, abort, dp_out,
      output busy, done, in_addr, weight_addr, input_register,
             acc_reset, acc_en, result_we, result_addr, result_data
   );

   modport slave (
      output start, abort, dp_out,
      input  busy, done, in_addr, weight_addr, input_register,
             acc_reset, acc_en, result_we, result_addr, result_data
   );
endinterface

// File: rtl/neuron_sequencer.sv
// Control FSM for the neuron MAC datapath: per neuron it clears the
// accumulator, streams N_INPUTS ROM addresses, drains the last product and
// writes the saturated result; a one-cycle done pulse ends the layer.
// Optional macro NEURON_SEQ_ABORT_EN enables the synchronous abort input.
module neuron_sequencer #(
   parameter int N_INPUTS  = 16,
   parameter int N_NEURONS = 8,
   parameter int IN_AW     = 4,
   parameter int W_AW      = 7,
   parameter int N_AW      = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   neuron_sequencer_if.master  bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [IN_AW-1:0] I_LAST = IN_AW'(N_INPUTS - 1);
   localparam logic [N_AW-1:0]  N_LAST = N_AW'(N_NEURONS - 1);

   logic [2:0]       state_q, state_d;
   logic [IN_AW-1:0] i_q, i_d;
   logic [N_AW-1:0]  n_q, n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             in_reg_q, in_reg_d;
   logic             acc_reset_q, acc_reset_d;
   logic             acc_en_q, acc_en_d;
   logic             result_we_q, result_we_d;
   logic [N_AW-1:0]  result_addr_q, result_addr_d;
   logic [7:0]       result_data_q, result_data_d;

`ifndef NEURON_SEQ_ABORT_EN
   logic unused_abort;
   assign unused_abort = bus.abort;
`endif

   // Next state, counters and next values of the registered outputs
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLEAR;
               i_d     = '0;
               n_d     = '0;
            end
         end
         S_CLEAR: state_d = S_LOAD;
         S_LOAD: begin
            if (i_q == I_LAST) begin
               i_d     = '0;
               state_d = S_DRAIN;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: begin
            if (n_q == N_LAST) begin
               state_d = S_DONE;
            end else begin
               n_d     = n_q + 1'b1;
               state_d = S_CLEAR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef NEURON_SEQ_ABORT_EN
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         i_d     = '0;
         n_d     = '0;
      end
`endif
      // Strobes are decoded from the state being entered so they line up
      // with that state's cycle. acc_en follows input_register by one cycle
      // and result_we follows WRITE by one cycle (so dp_out is captured
      // after the last accumulate); both are dropped when falling to IDLE.
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
      acc_reset_d   = (state_d == S_CLEAR);
      in_reg_d      = (state_d == S_LOAD);
      acc_en_d      = in_reg_q && (state_d != S_IDLE);
      result_we_d   = (state_q == S_WRITE) && (state_d != S_IDLE);
      result_addr_d = result_addr_q;
      result_data_d = result_data_q;
      if (result_we_d) begin
         result_addr_d = n_q;
         result_data_d = bus.dp_out;
      end
   end

   // State, counter and output registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         i_q           <= '0;
         n_q           <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         in_reg_q      <= 1'b0;
         acc_reset_q   <= 1'b0;
         acc_en_q      <= 1'b0;
         result_we_q   <= 1'b0;
         result_addr_q <= '0;
         result_data_q <= '0;
      end else begin
         state_q       <= state_d;
         i_q           <= i_d;
         n_q           <= n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         in_reg_q      <= in_reg_d;
         acc_reset_q   <= acc_reset_d;
         acc_en_q      <= acc_en_d;
         result_we_q   <= result_we_d;
         result_addr_q <= result_addr_d;
         result_data_q <= result_data_d;
      end
   end

   assign bus.in_addr        = i_q;
   assign bus.weight_addr    = W_AW'(n_q) * W_AW'(N_INPUTS) + W_AW'(i_q);
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.input_register = in_reg_q;
   assign bus.acc_reset      = acc_reset_q;
   assign bus.acc_en         = acc_en_q;
   assign bus.result_we      = result_we_q;
   assign bus.result_addr    = result_addr_q;
   assign bus.result_data    = result_data_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer with a behavioural MAC datapath
// and a scoreboard of expected result-buffer writes.
module tb_neuron_sequencer;
   localparam int NI  = 4;
   localparam int NN  = 2;
   localparam int IAW = 2;
   localparam int WAW = 3;
   localparam int NAW = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   neuron_sequencer_if #(.IN_AW(IAW), .W_AW(WAW), .N_AW(NAW)) bus ();

   neuron_sequencer #(
      .N_INPUTS (NI),
      .N_NEURONS(NN),
      .IN_AW    (IAW),
      .W_AW     (WAW),
      .N_AW     (NAW)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;

   logic [7:0] in_rom [NI];
   logic [7:0] w_rom  [NI*NN];

   // behavioural datapath: operand registers, accumulator, 8-bit saturation
   logic [7:0] x_r, w_r;
   int         acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r <= '0;
         w_r <= '0;
         acc <= 0;
      end else begin
         if (bus.input_register) begin
            x_r <= in_rom[bus.in_addr];
            w_r <= w_rom[bus.weight_addr];
         end
         if (bus.acc_reset)   acc <= 0;
         else if (bus.acc_en) acc <= acc + int'(x_r) * int'(w_r);
      end
   end
   assign bus.dp_out = (acc > 255) ? 8'hFF : acc[7:0];

   typedef struct {
      logic [NAW-1:0] addr;
      logic [7:0]     data;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   // scoreboard consumer and per-cycle exclusivity rules
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.result_we === 1'b1) begin
            n_writes++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: write addr=%0d data=%0d, required no write",
                        bus.result_addr, bus.result_data);
            end else begin
               e = sb.pop_front();
               if ({bus.result_addr, bus.result_data} !== {e.addr, e.data}) begin
                  n_fail++;
                  $display("FAIL result_write: addr=%0d data=%0d, required addr=%0d data=%0d",
                           bus.result_addr, bus.result_data, e.addr, e.data);
               end
            end
         end
         if (bus.acc_reset || bus.acc_en) begin
            n_checks++;
            if ((bus.acc_reset & bus.acc_en) !== 1'b0) begin
               n_fail++;
               $display("FAIL excl_acc: acc_reset=%b acc_en=%b, required not both",
                        bus.acc_reset, bus.acc_en);
            end
         end
         if (bus.result_we || bus.input_register) begin
            n_checks++;
            if ((bus.result_we & bus.input_register) !== 1'b0) begin
               n_fail++;
               $display("FAIL excl_we: result_we=%b input_register=%b, required not both",
                        bus.result_we, bus.input_register);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] out_vec();
      return {bus.busy, bus.done, bus.in_addr, bus.weight_addr, bus.input_register,
              bus.acc_reset, bus.acc_en, bus.result_we, bus.result_addr, bus.result_data};
   endfunction

   task automatic push_layer();
      for (int n = 0; n < NN; n++) begin
         int   sum;
         exp_t x;
         sum = 0;
         for (int i = 0; i < NI; i++) sum += int'(in_rom[i]) * int'(w_rom[n*NI + i]);
         x.addr = NAW'(n);
         x.data = (sum > 255) ? 8'hFF : 8'(sum);
         sb.push_back(x);
      end
   endtask

   // pulse start in IDLE; returns just after the accepting edge (CLEAR cycle)
   task automatic start_layer();
      push_layer();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      tick();
      n_checks++;
      if (out_vec() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0", out_vec());
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      n_checks++;
      if ({bus.busy, bus.acc_reset} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_hold: busy=%b acc_reset=%b, required 0 0", bus.busy, bus.acc_reset);
      end
   endtask

   task automatic test_layer();
      int   done_c   = -1;
      int   n_rst    = 0;
      int   n_ld     = 0;
      int   n_en     = 0;
      int   first_ld = -1;
      int   first_en = -1;
      int   wexp     = 0;
      int   w0       = n_writes;
      start_layer();
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) begin
            done_c = c;
            break;
         end
         n_checks++;
         if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_high: cycle %0d busy=%b, required 1", c, bus.busy);
         end
         if (bus.acc_reset) n_rst++;
         if (bus.acc_en) begin
            n_en++;
            if (first_en < 0) first_en = c;
         end
         if (bus.input_register) begin
            n_ld++;
            if (first_ld < 0) first_ld = c;
            n_checks++;
            if ({bus.weight_addr, bus.in_addr} !== {WAW'(wexp), IAW'(wexp % NI)}) begin
               n_fail++;
               $display("FAIL addr_seq: weight_addr=%0d in_addr=%0d, required %0d %0d",
                        bus.weight_addr, bus.in_addr, wexp, wexp % NI);
            end
            wexp++;
         end
         tick();
      end
      n_checks++;
      if (done_c !== NN*(NI+3)) begin
         n_fail++;
         $display("FAIL done_latency: got %0d cycles, required %0d", done_c, NN*(NI+3));
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_in_done: busy=%b, required 0", bus.busy);
      end
      n_checks++;
      if ({n_rst, n_ld, n_en} !== {32'(NN), 32'(NN*NI), 32'(NN*NI)}) begin
         n_fail++;
         $display("FAIL strobe_counts: acc_reset=%0d load=%0d acc_en=%0d, required %0d %0d %0d",
                  n_rst, n_ld, n_en, NN, NN*NI, NN*NI);
      end
      n_checks++;
      if ({first_ld, first_en} !== {32'd1, 32'd2}) begin
         n_fail++;
         $display("FAIL strobe_start: first load=%0d first acc_en=%0d, required 1 2",
                  first_ld, first_en);
      end
      tick();
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL done_pulse: done=%b busy=%b after pulse, required 0 0", bus.done, bus.busy);
      end
      n_checks++;
      if ((n_writes - w0) != NN || sb.size() != 0) begin
         n_fail++;
         $display("FAIL write_count: writes=%0d pending=%0d, required %0d 0",
                  n_writes - w0, sb.size(), NN);
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      start_layer();
      for (int c = 0; c < 40; c++) begin
         if (c == 3) bus.start = 1'b1;
         if (c == 4) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            ndone++;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            break;
         end
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         if (bus.done === 1'b1) ndone++;
         n_checks++;
         if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%b %0d cycles after layer, required 0", bus.busy, k);
         end
         tick();
      end
      n_checks++;
      if (ndone != 1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL single_done: done pulses=%0d pending=%0d, required 1 0", ndone, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int second = -1;
      push_layer();
      push_layer();
      bus.start = 1'b1;
      tick();
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) break;
         tick();
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_start_idle: busy=%b, required 0", bus.busy);
      end
      tick();
      bus.start = 1'b0;
      n_checks++;
      if ({bus.busy, bus.acc_reset} !== 2'b11) begin
         n_fail++;
         $display("FAIL held_start_retrigger: busy=%b acc_reset=%b, required 1 1",
                  bus.busy, bus.acc_reset);
      end
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) begin
            second = c;
            break;
         end
         tick();
      end
      n_checks++;
      if (second != NN*(NI+3)) begin
         n_fail++;
         $display("FAIL retrigger_latency: got %0d, required %0d", second, NN*(NI+3));
      end
      tick();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL retrigger_writes: pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      start_layer();
      for (int c = 0; c < 9; c++) tick();
      n_checks++;
      if ({bus.input_register, bus.weight_addr} !== {1'b1, WAW'(NI + 1)}) begin
         n_fail++;
         $display("FAIL mid_load: input_register=%b weight_addr=%0d, required 1 %0d",
                  bus.input_register, bus.weight_addr, NI + 1);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_vec() !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h, required 0", out_vec());
      end
      n_checks++;
      if (sb.size() != 1) begin
         n_fail++;
         $display("FAIL pre_reset_writes: pending=%0d, required 1", sb.size());
      end
      sb.delete();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
         tick();
      end
      n_checks++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL reset_abandon: %0d cycles busy/done after reset, required 0", ndone);
      end
      test_layer();
   endtask

   task automatic test_abort();
      start_layer();
      for (int c = 0; c < 13; c++) tick();
      n_checks++;
      if ({bus.busy, bus.input_register, bus.acc_en, bus.result_we} !== 4'b1000) begin
         n_fail++;
         $display("FAIL pre_abort_write: busy/load/acc_en/we=%b, required 1000",
                  {bus.busy, bus.input_register, bus.acc_en, bus.result_we});
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
`ifdef NEURON_SEQ_ABORT_EN
      n_checks++;
      if ({bus.done, bus.result_we, bus.busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_effect: done/we/busy=%b, required 000",
                  {bus.done, bus.result_we, bus.busy});
      end
      tick();
      tick();
      n_checks++;
      if (sb.size() != 1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_write: pending=%0d done=%b, required 1 0", sb.size(), bus.done);
      end
      sb.delete();
      test_layer();
`else
      n_checks++;
      if ({bus.done, bus.result_we, bus.busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL abort_ignored: done/we/busy=%b, required 110",
                  {bus.done, bus.result_we, bus.busy});
      end
      tick();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL abort_ignored_writes: pending=%0d, required 0", sb.size());
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < NI; i++) in_rom[i] = 8'd2;
      for (int i = 0; i < NI*NN; i++) w_rom[i] = 8'd3;
      test_reset();
      test_layer();
      // neuron 0 saturates (300 -> 255), neuron 1 gives 30
      for (int i = 0; i < NI; i++) begin
         in_rom[i]     = 8'(i + 1);
         w_rom[i]      = 8'(10 * (i + 1));
         w_rom[NI + i] = 8'(i + 1);
      end
      test_layer();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
